// File: rtl/reg_serial_tx_if.sv
// Start/Ready handshake and serial output bundle for reg_serial_tx.
interface reg_serial_tx_if;
  logic       Start;
  logic [7:0] Din;
  logic       Ready;
  logic       Busy;
  logic       TxD;
  logic       Done;

  modport master (output Start, Din, input Ready, Busy, TxD, Done);
  modport slave  (input Start, Din, output Ready, Busy, TxD, Done);
endinterface

// File: rtl/reg_serial_tx.sv
// Byte-to-serial frame transmitter: start bit, 8 data bits LSB first,
// optional even parity, stop bit; each bit held CLKS_PER_BIT clocks.
module reg_serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input logic           CLK,
  input logic           Reset,
  reg_serial_tx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [7:0] BAUD_MAX = 8'(CLKS_PER_BIT - 1);

  state_t     state;
  logic [7:0] shreg;
  logic       par;
  logic [2:0] bitcnt;
  logic [7:0] baud;
  logic       txd_q;
  logic       ready_q;
  logic       done_q;
  logic       bit_end;

  assign bit_end   = (baud == BAUD_MAX);
  assign bus.TxD   = txd_q;
  assign bus.Ready = ready_q;
  assign bus.Busy  = ~ready_q;
  assign bus.Done  = done_q;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state   <= S_IDLE;
      shreg   <= '0;
      par     <= 1'b0;
      bitcnt  <= '0;
      baud    <= '0;
      txd_q   <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == S_IDLE) begin
        if (bus.Start) begin
          shreg   <= bus.Din;
          par     <= ^bus.Din;
          baud    <= '0;
          state   <= S_START;
          txd_q   <= 1'b0;
          ready_q <= 1'b0;
        end
      end else if (!bit_end) begin
        baud <= baud + 8'd1;
      end else begin
        // The next bit's level is registered on the edge that ends the current bit.
        baud <= '0;
        unique case (state)
          S_START: begin
            state  <= S_DATA;
            bitcnt <= '0;
            txd_q  <= shreg[0];
          end
          S_DATA: begin
            if (bitcnt == 3'd7) begin
              if (PARITY_EN != 0) begin
                state <= S_PARITY;
                txd_q <= par;
              end else begin
                state <= S_STOP;
                txd_q <= 1'b1;
              end
            end else begin
              bitcnt <= bitcnt + 3'd1;
              shreg  <= shreg >> 1;
              txd_q  <= shreg[1];
            end
          end
          S_PARITY: begin
            state <= S_STOP;
            txd_q <= 1'b1;
          end
          S_STOP: begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end
          default: begin
            state   <= S_IDLE;
            txd_q   <= 1'b1;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_serial_tx.sv
// Bench for reg_serial_tx: three parameterisations checked every cycle against
// a frame-position model, plus literal expectations for the key scenarios.
module tb_reg_serial_tx;

  logic CLK = 1'b0;
  logic Reset = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int passed = 0;

  logic       start_a[3];
  logic [7:0] din_a[3];
  logic       txd_a[3], ready_a[3], busy_a[3], done_a[3];

  reg_serial_tx_if bus0 ();
  reg_serial_tx_if bus1 ();
  reg_serial_tx_if bus2 ();

  assign bus0.Start = start_a[0];
  assign bus0.Din   = din_a[0];
  assign bus1.Start = start_a[1];
  assign bus1.Din   = din_a[1];
  assign bus2.Start = start_a[2];
  assign bus2.Din   = din_a[2];

  assign txd_a[0] = bus0.TxD;  assign ready_a[0] = bus0.Ready;
  assign busy_a[0] = bus0.Busy; assign done_a[0] = bus0.Done;
  assign txd_a[1] = bus1.TxD;  assign ready_a[1] = bus1.Ready;
  assign busy_a[1] = bus1.Busy; assign done_a[1] = bus1.Done;
  assign txd_a[2] = bus2.TxD;  assign ready_a[2] = bus2.Ready;
  assign busy_a[2] = bus2.Busy; assign done_a[2] = bus2.Done;

  reg_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut0 (.CLK(CLK), .Reset(Reset), .bus(bus0));
  reg_serial_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1)) dut1 (.CLK(CLK), .Reset(Reset), .bus(bus1));
  reg_serial_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0)) dut2 (.CLK(CLK), .Reset(Reset), .bus(bus2));

  function automatic int cpb_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 2;
  endfunction

  function automatic int par_of(input int i);
    return (i == 2) ? 0 : 1;
  endfunction

  function automatic int flen(input int i);
    return (10 + par_of(i)) * cpb_of(i);
  endfunction

  // Line level at cycle t of a frame, from the bit position within the frame.
  function automatic int exp_txd(input logic [7:0] b, input int t, input int cpb, input int par);
    int idx;
    idx = t / cpb;
    if (idx == 0) return 0;
    if (idx <= 8) return int'(b[idx-1]);
    if (par != 0 && idx == 9) return int'(^b);
    return 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  bit         m_active[3];
  bit         m_done[3];
  int         m_t[3];
  logic [7:0] m_byte[3];

  always @(posedge CLK or negedge Reset) begin
    for (int i = 0; i < 3; i++) begin
      if (!Reset) begin
        m_active[i] = 1'b0;
        m_done[i]   = 1'b0;
        m_t[i]      = 0;
      end else begin
        m_done[i] = 1'b0;
        if (m_active[i]) begin
          m_t[i]++;
          if (m_t[i] == flen(i)) begin
            m_active[i] = 1'b0;
            m_done[i]   = 1'b1;
          end
        end else if (start_a[i]) begin
          m_active[i] = 1'b1;
          m_t[i]      = 0;
          m_byte[i]   = din_a[i];
        end
      end
    end
  end

  always @(negedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("txd[%0d]", i), int'(txd_a[i]),
          m_active[i] ? exp_txd(m_byte[i], m_t[i], cpb_of(i), par_of(i)) : 1);
      chk($sformatf("ready[%0d]", i), int'(ready_a[i]), int'(!m_active[i]));
      chk($sformatf("busy[%0d]", i), int'(busy_a[i]), int'(m_active[i]));
      chk($sformatf("done[%0d]", i), int'(done_a[i]), int'(m_done[i]));
    end
  end

  // Sends one byte; bits[k] holds the line level sampled at the start of bit slot k.
  task automatic send(input int i, input logic [7:0] b, input int inj,
                      output int done_cyc, output logic [10:0] bits, output int ndone);
    @(negedge CLK);
    start_a[i] = 1'b1;
    din_a[i]   = b;
    @(posedge CLK);
    #1;
    start_a[i] = 1'b0;
    din_a[i]   = ~b;
    done_cyc = -1;
    ndone    = 0;
    bits     = '1;
    for (int c = 0; c <= flen(i) + 4; c++) begin
      if (c % cpb_of(i) == 0 && c / cpb_of(i) < 11) bits[c / cpb_of(i)] = txd_a[i];
      if (done_a[i]) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c == inj) begin
        start_a[i] = 1'b1;
        din_a[i]   = 8'hC3;
      end else if (c == inj + 1) begin
        start_a[i] = 1'b0;
      end
      @(posedge CLK);
      #1;
    end
  endtask

  int         dcyc, nd, d1, d2;
  logic [10:0] bits;

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_a[i] = 1'b0;
      din_a[i]   = 8'h00;
    end

    // Reset held with Start toggling
    repeat (6) begin
      @(negedge CLK);
      for (int i = 0; i < 3; i++) start_a[i] = ~start_a[i];
    end
    #1;
    chk("rst txd", int'(txd_a[0]), 1);
    chk("rst ready", int'(ready_a[0]), 1);
    chk("rst busy", int'(busy_a[0]), 0);
    chk("rst done", int'(done_a[0]), 0);
    for (int i = 0; i < 3; i++) start_a[i] = 1'b0;
    @(negedge CLK);
    #2 Reset = 1'b1;
    repeat (2) @(posedge CLK);

    // 0xA5 frame, 4 clocks per bit with parity
    send(0, 8'hA5, -1, dcyc, bits, nd);
    chk("a5 bits", int'(bits), int'(11'b10101001010));
    chk("a5 done cycle", dcyc, 44);
    chk("a5 done count", nd, 1);

    // Parity values at 1 clock per bit
    send(1, 8'h01, -1, dcyc, bits, nd);
    chk("01 parity", int'(bits[9]), 1);
    chk("01 done cycle", dcyc, 11);
    send(1, 8'hFF, -1, dcyc, bits, nd);
    chk("ff parity", int'(bits[9]), 0);
    chk("ff done cycle", dcyc, 11);

    // Start while busy is ignored
    send(0, 8'h3C, 10, dcyc, bits, nd);
    chk("busy bits", int'(bits), int'(11'b10001111000));
    chk("busy done count", nd, 1);
    chk("busy done cycle", dcyc, 44);

    // Back-to-back frames, 2 clocks per bit, no parity
    @(negedge CLK);
    start_a[2] = 1'b1;
    din_a[2]   = 8'h55;
    @(posedge CLK);
    #1;
    din_a[2] = 8'hAA;
    d1 = -1;
    d2 = -1;
    nd = 0;
    for (int c = 0; c <= 50; c++) begin
      if (done_a[2]) begin
        nd++;
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      if (c == 2)  chk("b2b first bit0", int'(txd_a[2]), 1);
      if (c == 20) chk("b2b idle gap", int'(txd_a[2]), 1);
      if (c == 21) begin
        chk("b2b second start", int'(txd_a[2]), 0);
        start_a[2] = 1'b0;
      end
      if (c == 25) chk("b2b second bit1", int'(txd_a[2]), 1);
      @(posedge CLK);
      #1;
    end
    chk("b2b first done", d1, 20);
    chk("b2b done spacing", d2 - d1, 21);
    chk("b2b done count", nd, 2);

    // Reset during data bit 3, then a clean frame
    @(negedge CLK);
    start_a[0] = 1'b1;
    din_a[0]   = 8'h5A;
    @(posedge CLK);
    #1;
    start_a[0] = 1'b0;
    repeat (17) @(posedge CLK);
    #3;
    Reset = 1'b0;
    #1;
    chk("midrst txd", int'(txd_a[0]), 1);
    chk("midrst ready", int'(ready_a[0]), 1);
    chk("midrst busy", int'(busy_a[0]), 0);
    chk("midrst done", int'(done_a[0]), 0);
    repeat (3) @(negedge CLK);
    #2 Reset = 1'b1;
    send(0, 8'h81, -1, dcyc, bits, nd);
    chk("81 bits", int'(bits), int'(11'b10100000010));
    chk("81 done cycle", dcyc, 44);
    chk("81 done count", nd, 1);

    repeat (3) @(posedge CLK);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
